// File: rtl/btn_pkg.sv
// Shared definitions for the button conditioner: channel FSM encoding and agreement-counter width.
package btn_pkg;

   localparam int BTN_CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      PRESS_WAIT = 2'd1,
      HELD       = 2'd2,
      REL_WAIT   = 2'd3
   } btn_state_t;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchroniser, tick-driven debounce FSM, press pulse and level.
// Define BTN_REPEAT_EN to build the auto-repeat timer that adds pulses while the button is held.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// IDLE       | released and stable, waiting for a high sample
// PRESS_WAIT | counting consecutive high samples towards a confirmed press
// HELD       | press confirmed, level high (auto-repeat runs here if built)
// REL_WAIT   | counting consecutive low samples towards a confirmed release
module btn_debounce_ch
   import btn_pkg::*;
#(
   parameter int DEBOUNCE_CNT = 3,
   parameter int REPEAT_DELAY = 50,
   parameter int REPEAT_RATE  = 10
) (
   input  logic clk,
   input  logic clr,
   input  logic tick,
   input  logic inp,
   output logic outp,
   output logic level
);

   localparam logic [BTN_CNT_W-1:0] DB_LAST = BTN_CNT_W'(DEBOUNCE_CNT - 1);
   localparam bit DB_ONE = (DEBOUNCE_CNT == 1);

   btn_state_t state;
   logic [BTN_CNT_W-1:0] cnt;
   logic [1:0] sync;
   logic s;

   assign s = sync[1];

`ifdef BTN_REPEAT_EN
   localparam int REP_W = 16;
   localparam logic [REP_W-1:0] REP_DELAY_V = REP_W'(REPEAT_DELAY);
   localparam logic [REP_W-1:0] REP_RATE_V  = REP_W'(REPEAT_RATE);
   logic [REP_W-1:0] rep_tmr;
`else
   logic unused_repeat_cfg;
   assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_RATE};
`endif

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) sync <= 2'b00;
      else      sync <= {sync[0], inp};
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state <= IDLE;
         cnt   <= '0;
         outp  <= 1'b0;
         level <= 1'b0;
`ifdef BTN_REPEAT_EN
         rep_tmr <= REP_DELAY_V;
`endif
      end else begin
         outp <= 1'b0;
         if (tick) begin
            case (state)
               IDLE: begin
`ifdef BTN_REPEAT_EN
                  rep_tmr <= REP_DELAY_V;
`endif
                  if (s) begin
                     if (DB_ONE) begin
                        state <= HELD;
                        level <= 1'b1;
                        outp  <= 1'b1;
                        cnt   <= '0;
                     end else begin
                        state <= PRESS_WAIT;
                        cnt   <= BTN_CNT_W'(1);
                     end
                  end
               end
               PRESS_WAIT: begin
                  if (s) begin
                     if (cnt == DB_LAST) begin
                        state <= HELD;
                        level <= 1'b1;
                        outp  <= 1'b1;
                        cnt   <= '0;
                     end else begin
                        cnt <= cnt + 1'b1;
                     end
                  end else begin
                     state <= IDLE;
                     cnt   <= '0;
                  end
               end
               HELD: begin
                  if (!s) begin
                     if (DB_ONE) begin
                        state <= IDLE;
                        level <= 1'b0;
                        cnt   <= '0;
                     end else begin
                        state <= REL_WAIT;
                        cnt   <= BTN_CNT_W'(1);
                     end
                  end else begin
`ifdef BTN_REPEAT_EN
                     // Timer only runs on ticks spent in HELD, so REL_WAIT bounces pause it.
                     if (rep_tmr == REP_W'(1)) begin
                        outp    <= 1'b1;
                        rep_tmr <= REP_RATE_V;
                     end else begin
                        rep_tmr <= rep_tmr - 1'b1;
                     end
`endif
                  end
               end
               REL_WAIT: begin
                  if (!s) begin
                     if (cnt == DB_LAST) begin
                        state <= IDLE;
                        level <= 1'b0;
                        cnt   <= '0;
                     end else begin
                        cnt <= cnt + 1'b1;
                     end
                  end else begin
                     state <= HELD;
                     cnt   <= '0;
                  end
               end
               default: begin
                  state <= IDLE;
                  cnt   <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: rtl/btn_pulse_gen.sv
// Multi-channel button conditioner: shared sample-tick prescaler feeding N debounce channels.
// Auto-repeat on held buttons is built only when BTN_REPEAT_EN is defined.
module btn_pulse_gen
   import btn_pkg::*;
#(
   parameter int N            = 2,
   parameter int SAMPLE_DIV   = 500000,
   parameter int DEBOUNCE_CNT = 3,
   parameter int REPEAT_DELAY = 50,
   parameter int REPEAT_RATE  = 10
) (
   input  logic         clk,
   input  logic         clr,
   input  logic [N-1:0] inp,
   output logic [N-1:0] outp,
   output logic [N-1:0] level,
   output logic         tick
);

   localparam int PRE_W = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SAMPLE_DIV - 1);

   logic [PRE_W-1:0] pre;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr)                pre <= '0;
      else if (pre == PRE_LAST) pre <= '0;
      else                     pre <= pre + 1'b1;
   end

   assign tick = (pre == PRE_LAST);

   for (genvar i = 0; i < N; i++) begin : g_ch
      btn_debounce_ch #(
         .DEBOUNCE_CNT (DEBOUNCE_CNT),
         .REPEAT_DELAY (REPEAT_DELAY),
         .REPEAT_RATE  (REPEAT_RATE)
      ) u_ch (
         .clk   (clk),
         .clr   (clr),
         .tick  (tick),
         .inp   (inp[i]),
         .outp  (outp[i]),
         .level (level[i])
      );
   end

endmodule

// File: tb/tb_btn_pulse_gen.sv
// Scoreboard bench for btn_pulse_gen with SAMPLE_DIV=4, DEBOUNCE_CNT=3, N=2.
// Expected pulses are queued as (edge index since reset release, outp value).
module tb_btn_pulse_gen;

   logic       clk = 1'b0;
   logic       clr = 1'b0;
   logic [1:0] inp = 2'b00;
   logic [1:0] outp;
   logic [1:0] level;
   logic       tick;

   always #5 clk = ~clk;

   btn_pulse_gen #(
      .N            (2),
      .SAMPLE_DIV   (4),
      .DEBOUNCE_CNT (3),
      .REPEAT_DELAY (5),
      .REPEAT_RATE  (2)
   ) dut (
      .clk   (clk),
      .clr   (clr),
      .inp   (inp),
      .outp  (outp),
      .level (level),
      .tick  (tick)
   );

   typedef struct {
      int         cyc;
      logic [1:0] val;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc   = 0;

   // Posedge index since the last reset release; tick edges are multiples of 4.
   always @(posedge clk) begin
      if (!clr) cyc = 0;
      else      cyc = cyc + 1;
   end

   always @(negedge clk) begin
      exp_t e;
      if (outp !== 2'b00) begin
         n_cmp++;
         if (sb.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_pulse: outp=%b at cyc %0d, no pulse expected", outp, cyc);
         end else begin
            e = sb.pop_front();
            if (e.cyc != cyc || outp !== e.val || (level & e.val) !== e.val) begin
               n_err++;
               $display("FAIL pulse: got outp=%b level=%b at cyc %0d, expected outp=%b with level set at cyc %0d",
                        outp, level, cyc, e.val, e.cyc);
            end
         end
      end
   end

   task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic expect_pulse(input int c, input logic [1:0] v);
      sb.push_back('{c, v});
   endtask

   task automatic wait_cyc(input int n);
      int guard = 0;
      while (cyc != n) begin
         @(negedge clk);
         guard++;
         if (guard > 1000) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_cyc: cyc stuck at %0d, required %0d", cyc, n);
            return;
         end
      end
   endtask

   task automatic do_reset(input logic [1:0] v);
      @(negedge clk);
      clr = 1'b0;
      inp = v;
      repeat (3) @(negedge clk);
      clr = 1'b1;
   endtask

   initial begin
      // Reset state and prescaler phase
      repeat (3) @(negedge clk);
      check("rst_outp", outp, 2'b00);
      check("rst_level", level, 2'b00);
      check("rst_tick", {1'b0, tick}, 2'b00);
      clr = 1'b1;
      wait_cyc(3);
      check("tick_at_3", {1'b0, tick}, 2'b01);
      wait_cyc(4);
      check("tick_at_4", {1'b0, tick}, 2'b00);

      // Clean press on channel 0, held 40 clk
      inp = 2'b01;
      expect_pulse(16, 2'b01);
      wait_cyc(20);
      check("clean_level_hi", level, 2'b01);
      wait_cyc(44);
      inp = 2'b00;
      wait_cyc(55);
      check("clean_rel_before", level, 2'b01);
      wait_cyc(56);
      check("clean_rel_after", level, 2'b00);
      wait_cyc(70);

      // Press bounce 1,0,1 then steady; unsampled glitch on channel 1
      do_reset(2'b00);
      wait_cyc(4);
      inp = 2'b01;
      wait_cyc(8);
      inp = 2'b00;
      wait_cyc(12);
      inp = 2'b11;
      expect_pulse(24, 2'b01);
      wait_cyc(13);
      inp = 2'b01;
      wait_cyc(20);
      check("bounce_not_yet", level, 2'b00);
      wait_cyc(25);
      check("bounce_level", level, 2'b01);

      // Release bounce: 1-tick low is ignored, 3-tick low releases without a pulse
      wait_cyc(28);
      inp = 2'b00;
      wait_cyc(32);
      inp = 2'b01;
      wait_cyc(38);
      check("relbounce_hold", level, 2'b01);
      wait_cyc(40);
      inp = 2'b00;
      wait_cyc(51);
      check("release_before", level, 2'b01);
      wait_cyc(52);
      check("release_after", level, 2'b00);
      wait_cyc(64);

      // Simultaneous press
      do_reset(2'b00);
      wait_cyc(5);
      inp = 2'b11;
      expect_pulse(16, 2'b11);
      wait_cyc(17);
      check("simul_level", level, 2'b11);
      wait_cyc(24);

      // Held through reset, then reset mid PRESS_WAIT
      do_reset(2'b10);
      expect_pulse(12, 2'b10);
      wait_cyc(16);
      inp = 2'b11;
      wait_cyc(24);
      check("pre_reset_level", level, 2'b10);
      wait_cyc(25);
      clr = 1'b0;
      #1;
      check("midrst_outp", outp, 2'b00);
      check("midrst_level", level, 2'b00);
      check("midrst_tick", {1'b0, tick}, 2'b00);
      repeat (2) @(negedge clk);
      clr = 1'b1;
      expect_pulse(12, 2'b11);
      wait_cyc(13);
      check("post_reset_level", level, 2'b11);
      wait_cyc(30);

`ifdef BTN_REPEAT_EN
      // Auto-repeat: first pulse, +5 ticks, then every 2 ticks until release
      do_reset(2'b00);
      inp = 2'b01;
      expect_pulse(12, 2'b01);
      for (int t = 32; t <= 88; t += 8) expect_pulse(t, 2'b01);
      wait_cyc(92);
      inp = 2'b00;
      wait_cyc(120);
      check("repeat_released", level, 2'b00);
`endif

      repeat (5) @(negedge clk);
      while (sb.size() != 0) begin
         exp_t e;
         e = sb.pop_front();
         n_cmp++;
         n_err++;
         $display("FAIL missing_pulse: got none, expected outp=%b at cyc %0d", e.val, e.cyc);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete, %0d mismatched so far", n_err);
      $fatal(1, "timeout");
   end

endmodule
